// File: rtl/data_mem_sweep.sv
`timescale 1ns/1ps
// Parametrised DW x 2**AW data memory: one write port, two registered write-first read
// ports, and a hardware clear sweep after reset or InitReq. Optional parity: DATA_MEM_PARITY_EN.
module data_mem_sweep #(
  parameter int unsigned     DW        = 8,
  parameter int unsigned     AW        = 8,
  parameter logic [DW-1:0]   CLEAR_VAL = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InitReq,
  input  logic          WriteEn,
  input  logic [AW-1:0] WriteAddr,
  input  logic [DW-1:0] WriteData,
  input  logic [AW-1:0] ReadAddrA,
  input  logic [AW-1:0] ReadAddrB,
  output logic [DW-1:0] DataOutA,
  output logic [DW-1:0] DataOutB,
`ifdef DATA_MEM_PARITY_EN
  output logic          ParityErrA,
  output logic          ParityErrB,
`endif
  output logic          Busy
);

`ifdef DATA_MEM_PARITY_EN
  localparam int unsigned MW = DW + 1;
`else
  localparam int unsigned MW = DW;
`endif

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   cnt, cnt_nxt, cnt_inc;

  // Stored word: even-parity bit above the data when parity is enabled.
  function automatic logic [MW-1:0] encode(input logic [DW-1:0] d);
`ifdef DATA_MEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through this block leaves a variable unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + 1'b1;
    case (state)
      ST_CLEAR: begin
        cnt_nxt = cnt_inc;
        // The edge that writes the last word also leaves CLEAR, so the sweep is 2**AW cycles.
        if (cnt_inc[AW]) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (InitReq) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign Busy = (state == ST_CLEAR);

  logic [MW-1:0] mem [0:(1<<AW)-1];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdata;

  // The sweep owns the write port while busy; the datapath write is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = WriteAddr;
    mem_wdata = encode(WriteData);
    if (Busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt[AW-1:0];
      mem_wdata = encode(CLEAR_VAL);
    end else if (WriteEn) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset; the clear sweep initialises it instead.
  always_ff @(posedge Clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  logic [MW-1:0] rd_a, rd_b;
  logic          fwd_a, fwd_b;

  assign rd_a  = mem[ReadAddrA];
  assign rd_b  = mem[ReadAddrB];
  assign fwd_a = WriteEn && (WriteAddr == ReadAddrA);
  assign fwd_b = WriteEn && (WriteAddr == ReadAddrB);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataOutA <= '0;
      DataOutB <= '0;
    end else if (Busy) begin
      DataOutA <= CLEAR_VAL;
      DataOutB <= CLEAR_VAL;
    end else begin
      DataOutA <= fwd_a ? WriteData : rd_a[DW-1:0];
      DataOutB <= fwd_b ? WriteData : rd_b[DW-1:0];
    end
  end

`ifdef DATA_MEM_PARITY_EN
  // A forwarded word never touched the array, so it cannot carry a parity error.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ParityErrA <= 1'b0;
      ParityErrB <= 1'b0;
    end else if (Busy) begin
      ParityErrA <= 1'b0;
      ParityErrB <= 1'b0;
    end else begin
      ParityErrA <= !fwd_a && (^rd_a);
      ParityErrB <= !fwd_b && (^rd_b);
    end
  end
`endif

endmodule
